alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Iterative multi-cycle RV32M multiply/divide unit beside the single-cycle ALU in EX.
//  Accepts one op via valid/ready and computes radix-2, one bit per cycle.
//  Returns a DATA_WIDTH result via valid/ready. Supports flush for pipeline squash.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width (even, >=8)
//  OPCODE_LENGTH  3   Operation width; encoding = RV32M funct3
// PORTS
//  clk         in   1               clock, rising edge
//  reset       in   1               asynchronous, active-high reset
//  in_valid    in   1               operation offered
//  in_ready    out  1               unit can accept (state IDLE)
//  SrcA        in   DATA_WIDTH      rs1 / dividend / multiplicand
//  SrcB        in   DATA_WIDTH      rs2 / divisor / multiplier
//  Operation   in   OPCODE_LENGTH   000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  flush       in   1               abort in-flight op, drop result
//  out_valid   out  1               Result valid, held until out_ready
//  out_ready   in   1               consumer takes Result
//  ALUResult   out  DATA_WIDTH      result
// BEHAVIOUR
//  Reset (async): state=IDLE, in_ready=1, out_valid=0, ALUResult=0, datapath regs=0.
//  Accept: edge with in_valid&&in_ready latches SrcA/SrcB/Operation; later input changes ignored.
//  FSM: IDLE -> CALC (W cycles) -> FIX (1 cycle) -> DONE; DONE -> IDLE on out_ready.
//   Special cases: IDLE -> DONE directly.
//  Latency: normal op out_valid rises at edge accept+W+2 (34 for W=32).
//   Special case out_valid rises at edge accept+1.
//  Latch: operand magnitudes, result sign, op. Signed: DIV,REM,MULH (both operands), MULHSU (A only).
//  MUL*: shift-add on magnitudes into 2W-bit product. FIX negates if sign set.
//   MUL returns low W bits; MULH/MULHSU/MULHU return high W bits.
//  DIV*: restoring division, W steps, W+1-bit partial remainder.
//   FIX: quotient sign = sA^sB; remainder sign = sA.
//  Special cases, no CALC:
//   divisor==0: DIV/DIVU = all ones; REM/REMU = SrcA.
//   DIV/REM with SrcA=MIN_INT, SrcB=-1: DIV = MIN_INT; REM = 0.
//  DONE: ALUResult and out_valid stable until out_ready=1. Next edge returns to IDLE, out_valid=0.
//   No accept while DONE (in_ready=0), so no same-cycle accept/return.
//  flush: any state -> IDLE at next edge. out_valid=0, result dropped.
//   flush wins over in_valid in IDLE (nothing accepted).
//  ALUResult holds last value outside DONE; consumers qualify with out_valid.
//  Reset mid-operation: immediate IDLE, outputs to reset values, no partial result.
//  Iteration counter: $clog2(DATA_WIDTH)+1 bits, counts W-1 down to 0. CALC -> FIX when count==0.
// STRUCTURE
//  Package muldiv_pkg: op enum muldiv_op_e (8 funct3 codes); state enum muldiv_state_e {IDLE,CALC,FIX,DONE};
//   helpers is_div(op), is_signed_a(op), is_signed_b(op).
//  One sub-module muldiv_step (combinational):
//   one shift-add or restore-subtract iteration: {acc, operand, mode} -> {acc_next}.
//  Top holds FSM, counter, operand/sign regs, fixup negation, output register.
// TESTING (W=32)
//  1. MUL 7 * -3: ALUResult=0xFFFFFFEB; out_valid exactly 34 cycles after accept.
//     Also MULHU 0xFFFFFFFF*0xFFFFFFFF=0xFFFFFFFE; MULH 0x80000000*0x80000000=0x40000000;
//     MULHSU 0xFFFFFFFF*0xFFFFFFFF=0xFFFFFFFF.
//  2. DIV -7/2 = 0xFFFFFFFD; REM -7/2 = 0xFFFFFFFF.
//     DIVU 100/7 = 14; REMU 100/7 = 2.
//  3. Special cases, out_valid 1 cycle after accept:
//     DIV 5/0 = 0xFFFFFFFF; REMU 5/0 = 5;
//     DIV 0x80000000/0xFFFFFFFF = 0x80000000; REM of same = 0.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE.
//     ALUResult/out_valid stable; in_ready=0; in_valid pulses ignored.
//  5. flush at CALC cycle 10: IDLE/in_ready=1 next cycle; no out_valid ever; next MUL 3*4 = 12.
//  6. Reset at CALC cycle 5: outputs reset immediately (async).
//     After release, DIVU 9/3 returns 3 at +34 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_pkg                                                    |
// | Description : Shared types and helpers for the iterative RV32M mul/div unit |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package muldiv_pkg;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_step                                                   |
// | Description : One radix-2 iteration: shift-add multiply or restoring divide |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
// Accumulator layout (2W+1 bits):
//   multiply : {upper partial product (W+1), multiplier bits still to consume (W)}
//   divide   : {partial remainder (W+1), dividend bits -> quotient bits (W)}
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH:0]  acc,
    input  logic [DATA_WIDTH-1:0]  operand,
    input  logic                   mode,      // 1 = divide, 0 = multiply
    output logic [2*DATA_WIDTH:0]  acc_next
);
    localparam int W = DATA_WIDTH;

    logic [W:0] w_sum;
    logic [W:0] w_rem_shift;
    logic [W:0] w_trial;

    // Single iteration of either algorithm; the partial remainder never exceeds W bits,
    // so shifting drops only its always-zero top bit.
    always_comb begin
        w_sum       = acc[2*W:W] + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});
        w_rem_shift = acc[2*W-1:W-1];
        w_trial     = w_rem_shift - {1'b0, operand};
        acc_next    = '0;
        if (mode) begin
            if (w_trial[W]) begin
                acc_next = {w_rem_shift, acc[W-2:0], 1'b0};
            end else begin
                acc_next = {w_trial, acc[W-2:0], 1'b1};
            end
        end else begin
            acc_next = {1'b0, w_sum, acc[W-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_muldiv                                                    |
// | Description : Iterative RV32M multiply/divide unit, valid/ready in and out  |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [W-1:0]  C_MIN_INT  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  C_ALL_ONES = {W{1'b1}};
    localparam logic [CW-1:0] C_LAST_CNT = CW'(W - 1);

    muldiv_state_e r_state, w_next_state;
    muldiv_op_e    r_op, w_op;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_opnd;
    logic [W-1:0]  r_res;
    logic [2*W:0]  r_acc;
    logic [2*W:0]  w_acc_step;
    logic          r_neg;

    logic          w_accept, w_a_neg, w_b_neg, w_neg;
    logic          w_div_zero, w_ovf, w_special;
    logic [W-1:0]  w_mag_a, w_mag_b, w_special_res;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]  w_div_raw, w_div_fix, w_fix_res;

    assign w_op = muldiv_op_e'(Operation);

    // Decode the offered operation: magnitudes, result sign and early-out cases
    always_comb begin
        w_a_neg    = is_signed_a(w_op) && SrcA[W-1];
        w_b_neg    = is_signed_b(w_op) && SrcB[W-1];
        w_mag_a    = w_a_neg ? -SrcA : SrcA;
        w_mag_b    = w_b_neg ? -SrcB : SrcB;
        w_neg      = is_rem(w_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero = is_div(w_op) && (SrcB == '0);
        w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                     (SrcA == C_MIN_INT) && (SrcB == C_ALL_ONES);
        w_special  = w_div_zero || w_ovf;
        if (w_div_zero) begin
            w_special_res = is_rem(w_op) ? SrcA : C_ALL_ONES;
        end else begin
            w_special_res = is_rem(w_op) ? '0 : C_MIN_INT;
        end
        w_accept = (r_state == IDLE) && in_valid && !flush;
    end

    muldiv_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .acc      (r_acc),
        .operand  (r_opnd),
        .mode     (is_div(r_op)),
        .acc_next (w_acc_step)
    );

    // Sign fixup and selection of the architectural result half
    always_comb begin
        w_prod    = r_neg ? -r_acc[2*W-1:0] : r_acc[2*W-1:0];
        w_div_raw = is_rem(r_op) ? r_acc[2*W-1:W] : r_acc[W-1:0];
        w_div_fix = r_neg ? -w_div_raw : w_div_raw;
        if (is_div(r_op)) begin
            w_fix_res = w_div_fix;
        end else if (r_op == OP_MUL) begin
            w_fix_res = w_prod[W-1:0];
        end else begin
            w_fix_res = w_prod[2*W-1:W];
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake logic; flush aborts from any state
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    w_next_state = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    w_next_state = IDLE;
                end else if (r_count == '0) begin
                    w_next_state = FIX;
                end
            end
            FIX: begin
                w_next_state = flush ? IDLE : DONE;
            end
            DONE: begin
                if (flush || (out_valid && out_ready)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand latch, iteration and fixup datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= OP_MUL;
            r_neg   <= 1'b0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_res   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_neg   <= w_neg;
                        r_count <= C_LAST_CNT;
                        r_opnd  <= is_div(w_op) ? w_mag_b : w_mag_a;
                        r_acc   <= {{(W+1){1'b0}}, (is_div(w_op) ? w_mag_a : w_mag_b)};
                        if (w_special) begin
                            r_res <= w_special_res;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_acc_step;
                    if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                    end
                end
                FIX: begin
                    r_res <= w_fix_res;
                end
                default: ;
            endcase
        end
    end

    // Output register: loads on the first DONE cycle, holds until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            ALUResult <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (r_state == DONE) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                ALUResult <= r_res;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_muldiv                                                 |
// | Description : Directed scoreboard bench for the iterative mul/div unit      |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_alu_muldiv;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [2:0]  Operation = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ALUResult;

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    alu_muldiv #(
        .DATA_WIDTH    (32),
        .OPCODE_LENGTH (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every completed output handshake is compared against the queue head
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", ALUResult);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, ALUResult, e.val);
            end
        end
    end

    // Offer one op at the next negedge; returns after the accept edge (+1)
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        Operation = DIVU;
        SrcA      = 32'hDEAD_BEEF;
        SrcB      = 32'h1234_5678;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        exp_q.push_back('{exp, name});
        issue(op, a, b);
        wait_valid(cyc);
        check({"lat ", name}, cyc, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        int seen;

        // Reset state
        #1;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst ALUResult", ALUResult, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Multiplies
        do_op("MUL 7*-3",      MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        do_op("MULHU -1*-1",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        do_op("MULH min*min",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        do_op("MULHSU -1*max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);

        // Divides
        do_op("DIV -7/2",   DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        do_op("REM -7/2",   REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        do_op("DIVU 100/7", DIVU, 32'd100,       32'd7, 32'd14,        34);
        do_op("REMU 100/7", REMU, 32'd100,       32'd7, 32'd2,         34);

        // Early-out cases
        do_op("DIV 5/0",       DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        do_op("REMU 5/0",      REMU, 32'd5,         32'd0,         32'd5,         1);
        do_op("DIV min/-1",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("REM min/-1",    REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Backpressure in DONE
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_q.push_back('{32'hFFFF_FFFE, "MULHU bp"});
        issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(cyc);
        check("lat MULHU bp", cyc, 34);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            Operation = MUL;
            SrcA      = i;
            SrcB      = 32'd1;
            @(posedge clk); #1;
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
            check("bp ALUResult", ALUResult, 32'hFFFF_FFFE);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp released out_valid", {31'd0, out_valid}, 32'd0);
        check("bp released in_ready", {31'd0, in_ready}, 32'd1);

        // Flush mid-calculation
        issue(DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        check("flush out_valid", {31'd0, out_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush no output", seen, 0);

        // Flush beats in_valid in IDLE
        @(negedge clk);
        flush     = 1'b1;
        in_valid  = 1'b1;
        Operation = MUL;
        SrcA      = 32'd9;
        SrcB      = 32'd9;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush idle in_ready", {31'd0, in_ready}, 32'd1);

        do_op("MUL 3*4", MUL, 32'd3, 32'd4, 32'd12, 34);

        // Asynchronous reset mid-calculation
        issue(MUL, 32'd5, 32'd6);
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst ALUResult", ALUResult, 32'd0);
        check("arst out_valid", {31'd0, out_valid}, 32'd0);
        check("arst in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        do_op("DIVU 9/3", DIVU, 32'd9, 32'd3, 32'd3, 34);

        repeat (3) @(posedge clk);
        #1;
        check("queue drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
